// File: rtl/rx_pkg.sv
// Shared definitions for the deserializer/demux receiver: FSM encoding,
// default sync word and a counter-width helper.
package rx_pkg;

  // Receiver lock state
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

  // Default sync/idle word (K28.5-style 0xBC)
  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  // Width of the optional received-word counter
  localparam int unsigned WORD_COUNT_W = 16;

  // Bits needed to count 0..n-1, never less than one
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_deserializer.sv
// Serial-to-parallel front end: shifts one bit per clock into a word register
// (oldest bit ends up in the MSB) and flags, one cycle after the last bit of a
// word is sampled, that the register holds a complete word. A realign pulse
// restarts the word boundary on the bit being sampled at that edge.
module rx_deserializer
  import rx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  input  logic              realign,
  output logic [DATA_W-1:0] word,
  output logic              word_c
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);

  logic [CNT_W-1:0] bit_cnt;

  // Shift register and bits-since-boundary counter
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      word    <= '0;
      bit_cnt <= '0;
    end else begin
      word <= {word[DATA_W-2:0], data_in};
      if (realign) begin
        bit_cnt <= CNT_W'(1);
      end else if (bit_cnt == CNT_W'(DATA_W - 1)) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Counter at zero means the last DATA_W bits form one aligned word
  assign word_c = (bit_cnt == '0);

endmodule

// File: rtl/deserializador_demux_rx.sv
// Serial receiver with comma-based word lock and round-robin lane demux.
// Searches bit-by-bit for COMMA, confirms SYNC_COUNT aligned commas, then
// distributes each non-comma word to the next output lane with a one-cycle
// valid strobe. Commas after lock are idles.
// Optional feature: define RX_WORD_COUNT_EN to add a saturating 16-bit
// word_count output counting delivered words.
module deserializador_demux_rx
  import rx_pkg::*;
#(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       LANES      = 4,
  parameter logic [DATA_W-1:0] COMMA      = DATA_W'(COMMA_DEFAULT),
  parameter int unsigned       SYNC_COUNT = 4
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  input  logic                    data_in,
  output logic                    active,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        valid_out
`ifdef RX_WORD_COUNT_EN
  ,
  output logic [WORD_COUNT_W-1:0] word_count
`endif
);

  localparam int unsigned PTR_W = cnt_width(LANES);
  localparam int unsigned CC_W  = cnt_width(SYNC_COUNT + 1);

  rx_state_t         state;
  logic [CC_W-1:0]   comma_cnt;
  logic [PTR_W-1:0]  lane_ptr;
  logic [DATA_W-1:0] word;
  logic              word_c;
  logic              is_comma_c;
  logic              realign_c;
  logic              strobe_c;

  rx_deserializer #(
    .DATA_W (DATA_W)
  ) u_deser (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .realign (realign_c),
    .word    (word),
    .word_c  (word_c)
  );

  // Word classification and boundary control
  assign is_comma_c = (word == COMMA);
  assign realign_c  = (state == SEARCH) && is_comma_c;
  assign strobe_c   = (state == ACTIVE) && word_c && !is_comma_c;

  // Lock FSM and lane demux
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      comma_cnt <= '0;
      lane_ptr  <= '0;
      active    <= 1'b0;
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      valid_out <= '0;
      unique case (state)
        SEARCH: begin
          if (is_comma_c) begin
            comma_cnt <= CC_W'(1);
            if (SYNC_COUNT == 1) begin
              state    <= ACTIVE;
              active   <= 1'b1;
              lane_ptr <= '0;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (word_c) begin
            if (is_comma_c) begin
              comma_cnt <= comma_cnt + CC_W'(1);
              if (comma_cnt == CC_W'(SYNC_COUNT - 1)) begin
                state    <= ACTIVE;
                active   <= 1'b1;
                lane_ptr <= '0;
              end
            end else begin
              state     <= SEARCH;
              comma_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          if (strobe_c) begin
            for (int l = 0; l < LANES; l++) begin
              if (lane_ptr == PTR_W'(l)) begin
                data_out[l*DATA_W +: DATA_W] <= word;
                valid_out[l]                 <= 1'b1;
              end
            end
            lane_ptr <= (lane_ptr == PTR_W'(LANES - 1)) ? '0 : lane_ptr + PTR_W'(1);
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

`ifdef RX_WORD_COUNT_EN
  // Saturating count of delivered words
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      word_count <= '0;
    end else if (strobe_c && (word_count != '1)) begin
      word_count <= word_count + WORD_COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_deserializador_demux_rx.sv
// Bench for deserializador_demux_rx: a bit-history model tracks lock and lane
// delivery and is compared to the DUT every cycle; directed sequences add
// literal expectations. Define RX_WORD_COUNT_EN for the 10-bit/2-lane build.
module tb_deserializador_demux_rx;

`ifdef RX_WORD_COUNT_EN
  localparam int unsigned DW = 10;
  localparam int unsigned LN = 2;
  localparam logic [DW-1:0] CM = 10'h17C;
`else
  localparam int unsigned DW = 8;
  localparam int unsigned LN = 4;
  localparam logic [DW-1:0] CM = 8'hBC;
`endif
  localparam int unsigned SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in = 1'b0;
  logic active;
  logic [LN*DW-1:0] data_out;
  logic [LN-1:0] valid_out;
`ifdef RX_WORD_COUNT_EN
  logic [15:0] word_count;
`endif

  deserializador_demux_rx #(
    .DATA_W     (DW),
    .LANES      (LN),
    .COMMA      (CM),
    .SYNC_COUNT (SC)
  ) dut (
    .clk_32f   (clk),
    .reset     (rst_n),
    .data_in   (data_in),
    .active    (active),
    .data_out  (data_out),
    .valid_out (valid_out)
`ifdef RX_WORD_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cyc = -1;
  logic prev_active = 1'b0;
  int log_lane[$];
  logic [DW-1:0] log_data[$];

  // Model: mode 0=searching, 1=counting commas, 2=locked
  int m_mode, m_commas, m_anchor, m_t, m_ptr, m_count;
  logic [DW-1:0] m_win;
  logic [DW-1:0] m_lane [LN];
  logic [LN-1:0] m_valid;
  logic m_active;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_commas = 0; m_anchor = 0; m_t = 0; m_ptr = 0; m_count = 0;
    m_win = '0; m_valid = '0; m_active = 1'b0;
    for (int l = 0; l < LN; l++) m_lane[l] = '0;
  endtask

  // Apply one clock edge to the model; b is the bit sampled at that edge
  task automatic model_step(input logic b);
    m_valid = '0;
    if (m_mode == 0) begin
      if (m_win == CM) begin
        m_anchor = m_t - 1;
        m_commas = 1;
        if (SC == 1) begin m_mode = 2; m_ptr = 0; m_active = 1'b1; end
        else m_mode = 1;
      end
    end else if (((m_t - 1 - m_anchor) % DW) == 0) begin
      if (m_mode == 1) begin
        if (m_win == CM) begin
          m_commas++;
          if (m_commas == SC) begin m_mode = 2; m_ptr = 0; m_active = 1'b1; end
        end else begin
          m_mode = 0; m_commas = 0;
        end
      end else if (m_win != CM) begin
        m_lane[m_ptr] = m_win;
        m_valid[m_ptr] = 1'b1;
        m_ptr = (m_ptr + 1) % LN;
        if (m_count < 65535) m_count++;
      end
    end
    m_win = {m_win[DW-2:0], b};
    m_t++;
  endtask

  // Per-edge model update, DUT comparison and strobe logging
  always @(posedge clk) begin
    logic b;
    logic [LN*DW-1:0] exp_do;
    b = data_in;
    cyc++;
    if (!rst_n) model_reset();
    else model_step(b);
    #1;
    for (int l = 0; l < LN; l++) exp_do[l*DW +: DW] = m_lane[l];
    check("active", 64'(active), 64'(m_active));
    check("valid_out", 64'(valid_out), 64'(m_valid));
    check("data_out", 64'(data_out), 64'(exp_do));
    check("valid_onehot", 64'($countones(valid_out) <= 1), 64'(1));
`ifdef RX_WORD_COUNT_EN
    check("word_count", 64'(word_count), 64'(m_count));
`endif
    for (int l = 0; l < LN; l++) begin
      if (valid_out[l]) begin
        log_lane.push_back(l);
        log_data.push_back(data_out[l*DW +: DW]);
      end
    end
    if (active && !prev_active) rise_cyc = cyc;
    prev_active = active;
  end

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) begin
      @(negedge clk);
      data_in = w[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data_in = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_active", 64'(active), 64'(0));
    check("rst_valid", 64'(valid_out), 64'(0));
    check("rst_data", 64'(data_out), 64'(0));
`ifdef RX_WORD_COUNT_EN
    check("rst_word_count", 64'(word_count), 64'(0));
`endif
    rst_n = 1'b1;
    log_lane.delete();
    log_data.delete();
    rise_cyc = -1;
  endtask

  task automatic expect_strobes(input int n);
    check("strobe_count", 64'(log_lane.size()), 64'(n));
  endtask

  task automatic pop_strobe(input int lane, input logic [DW-1:0] d);
    if (log_lane.size() > 0) begin
      check("strobe_lane", 64'(log_lane.pop_front()), 64'(lane));
      check("strobe_data", 64'(log_data.pop_front()), 64'(d));
    end
  endtask

  initial begin
    int exp_rise;
    model_reset();
`ifdef RX_WORD_COUNT_EN
    // Lock on 10-bit comma, then six words alternate over two lanes
    do_reset();
    repeat (SC) send_word(CM);
    exp_rise = cyc + 2;
    for (int k = 1; k <= 6; k++) send_word(10'(k));
    send_word(CM);
    check("lock_edge_10b", 64'(rise_cyc), 64'(exp_rise));
    check("word_count_6", 64'(word_count), 64'(6));
    check("data_out_10b", 64'(data_out), 64'(20'h01805));
    expect_strobes(6);
    for (int k = 1; k <= 6; k++) pop_strobe((k - 1) % 2, 10'(k));
`else
    // Aligned lock after reset: active rises one edge after 4th comma, no strobes
    do_reset();
    repeat (SC) send_word(CM);
    exp_rise = cyc + 2;
    check("pre_lock_active", 64'(active), 64'(0));
    send_word(CM);
    check("lock_edge", 64'(rise_cyc), 64'(exp_rise));
    check("locked", 64'(active), 64'(1));
    expect_strobes(0);

    // Bit-level search after 3 junk bits, then round-robin lanes
    do_reset();
    @(negedge clk); data_in = 1'b1;
    @(negedge clk); data_in = 1'b0;
    @(negedge clk); data_in = 1'b1;
    repeat (SC) send_word(CM);
    send_word(8'h11); send_word(8'h22); send_word(8'h33);
    send_word(8'h44); send_word(8'h55); send_word(CM);
    check("junk_locked", 64'(active), 64'(1));
    check("lanes_after_55", 64'(data_out), 64'(32'h44332255));
    expect_strobes(5);
    pop_strobe(0, 8'h11); pop_strobe(1, 8'h22); pop_strobe(2, 8'h33);
    pop_strobe(3, 8'h44); pop_strobe(0, 8'h55);

    // Commas between data are idles and do not advance the pointer
    do_reset();
    repeat (SC) send_word(CM);
    send_word(8'hA1); send_word(CM); send_word(CM); send_word(8'hA2); send_word(CM);
    check("idle_lanes", 64'(data_out), 64'(32'h0000A2A1));
    expect_strobes(2);
    pop_strobe(0, 8'hA1); pop_strobe(1, 8'hA2);

    // Non-comma during alignment drops back to search
    do_reset();
    send_word(CM); send_word(CM); send_word(8'h00); send_word(CM);
    check("align_fail_inactive", 64'(active), 64'(0));
    send_word(CM); send_word(CM); send_word(CM);
    check("relock_pending", 64'(active), 64'(0));
    send_word(CM);
    check("relock_done", 64'(active), 64'(1));
    expect_strobes(0);

    // Asynchronous reset mid-word clears outputs; full relock required
    send_word(8'h77); send_word(CM);
    check("pre_reset_data", 64'(data_out), 64'(32'h00000077));
    for (int i = 7; i >= 4; i--) begin
      @(negedge clk); data_in = i[0];
    end
    @(negedge clk); data_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_active", 64'(active), 64'(0));
    check("async_data", 64'(data_out), 64'(0));
    check("async_valid", 64'(valid_out), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) send_word(CM);
    check("post_reset_3bc", 64'(active), 64'(0));
    send_word(CM); send_word(CM);
    check("post_reset_relock", 64'(active), 64'(1));
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/deserializador_demux_rx.md
DESERIALIZADOR_DEMUX_RX -- requirements
Module: deserializador_demux_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (>=4).
REQ-002 SHALL have parameter LANES, default 4, number of output lanes (>=1).
REQ-003 SHALL have parameter COMMA, default 8'hBC (DATA_W bits), sync/idle word.
REQ-004 SHALL have parameter SYNC_COUNT, default 4, consecutive COMMAs required for lock (>=1).
REQ-005 SHALL have port clk_32f input 1, the single bit-rate clock; all logic on its rising edge.
REQ-006 SHALL have port reset input 1, asynchronous, active-low.
REQ-007 SHALL have port data_in input 1, serial data, MSB first, one bit per clk_32f.
REQ-008 SHALL have port active output 1, high while locked.
REQ-009 SHALL have port data_out output LANES*DATA_W, lane l at bits [(l+1)*DATA_W-1 : l*DATA_W].
REQ-010 SHALL have port valid_out output LANES, one-cycle strobe per lane.

Function
REQ-011 SHALL shift data_in into the LSB of a DATA_W shift register every cycle; the assembled word holds the oldest bit in its MSB.
REQ-012 SHALL implement FSM states SEARCH, ALIGN, ACTIVE; reset state SEARCH.
REQ-013 In SEARCH, SHALL compare the shift register to COMMA every cycle (bit-level alignment); on match, SHALL set the word boundary there, set comma count to 1 and go to ALIGN, or directly to ACTIVE if SYNC_COUNT==1.
REQ-014 In ALIGN, at each word boundary (every DATA_W bits), a COMMA word SHALL increment comma count; reaching SYNC_COUNT SHALL enter ACTIVE and raise active on the next edge.
REQ-015 In ALIGN, a non-COMMA word SHALL return to SEARCH, clear comma count, and produce no valid_out.
REQ-016 In ACTIVE, a COMMA word SHALL be treated as idle: no valid_out, lane pointer unchanged.
REQ-017 In ACTIVE, a non-COMMA word SHALL be written to data_out lane at lane pointer, assert that lane's valid_out, and advance the pointer, wrapping LANES-1 -> 0.
REQ-018 Latency: if a word's last bit is sampled at edge n, data_out and valid_out SHALL update at edge n+1; valid_out SHALL be high exactly one cycle.
REQ-019 At most one valid_out bit SHALL be high in any cycle; words arrive every DATA_W cycles, so lanes never collide.
REQ-020 data_out lanes SHALL hold their last value until rewritten.
REQ-021 The lane pointer SHALL be 0 on entry to ACTIVE.
REQ-022 ACTIVE SHALL persist until reset; no loss-of-sync detection.

Reset
REQ-023 On reset low, SHALL asynchronously clear state to SEARCH, shift register, bit counter, comma count, lane pointer, active, data_out and valid_out to 0.
REQ-024 Reset asserted mid-word or mid-ALIGN SHALL discard partial words and require full re-lock after release.

Configuration
REQ-025 With RX_WORD_COUNT_EN defined, SHALL add output word_count (16 bits), reset 0, incremented on each valid_out strobe, saturating at 16'hFFFF; without it, the port and counter SHALL not exist.

Structure
REQ-026 Package rx_pkg SHALL hold the FSM state encoding and default COMMA constant.
REQ-027 Sub-module rx_deserializer SHALL contain the shift register, bit counter and word-boundary strobe; the top holds FSM and demux.

Verification
REQ-028 Reset low 5 cycles, then 4x 8'hBC aligned -> active rises at the edge after the last bit of the 4th BC; no valid_out strobes.
REQ-029 3 junk bits, then 4x BC -> lock achieved (bit-level search); then 8'h11,22,33,44,55 -> lanes 0..3 get 11,22,33,44; lane 0 then gets 55; each strobe one cycle.
REQ-030 After lock, 8'hA1, BC, BC, 8'hA2 -> lane0=A1, lane1=A2; no strobes during BCs.
REQ-031 BC, BC, 8'h00, BC -> returns to SEARCH after 8'h00, active stays 0; 4 further BCs -> lock.
REQ-032 Reset low mid-data (bit 3 of a word) -> all outputs 0 immediately; re-lock needs 4 BCs.
REQ-033 With RX_WORD_COUNT_EN, DATA_W=10, LANES=2, COMMA=10'h17C: lock then 6 data words -> word_count=6, lanes alternate 0,1.
